// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared screen geometry, position widths and motion state type
// Contents: SCREEN_W/SCREEN_H active area, X_W/Y_W position widths, motion_state_t.
package sprite_pkg;

    localparam int SCREEN_W = 1280;
    localparam int SCREEN_H = 720;
    localparam int X_W      = 11;
    localparam int Y_W      = 10;

    typedef enum logic [0:0] {
        MOVE = 1'b0,
        POP  = 1'b1
    } motion_state_t;

endpackage

// File: rtl/sprite_motion_ctrl_bounce_axis.sv
// rtl/sprite_motion_ctrl_bounce_axis.sv - one bouncing axis: position and direction
// Parameters: LIMIT screen extent, SIZE sprite extent, SPEED step per strobe,
//             INIT reset position, W position width.
// Ports: clk, rst_n (async active-low), step (advance strobe), pos (registered position).
module bounce_axis
    import sprite_pkg::*;
#(
    parameter int LIMIT = 1280,
    parameter int SIZE  = 256,
    parameter int SPEED = 2,
    parameter int INIT  = 0,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] pos
);

    // Far-wall reach is computed one bit wider so pos+SPEED+SIZE never wraps.
    logic         dir_neg;
    logic [W:0]   reach;
    logic         hit_far;
    logic         hit_near;

    assign reach    = {1'b0, pos} + (W+1)'(SPEED) + (W+1)'(SIZE);
    assign hit_far  = reach > (W+1)'(LIMIT);
    assign hit_near = {1'b0, pos} < (W+1)'(SPEED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= W'(INIT);
            dir_neg <= 1'b0;
        end else if (step) begin
            if (!dir_neg) begin
                // Also catches an out-of-range INIT: clamp and turn back.
                if (hit_far) begin
                    pos     <= W'(LIMIT - SIZE);
                    dir_neg <= 1'b1;
                end else begin
                    pos <= pos + W'(SPEED);
                end
            end else begin
                if (hit_near) begin
                    pos     <= '0;
                    dir_neg <= 1'b0;
                end else begin
                    pos <= pos - W'(SPEED);
                end
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - sprite position bouncer with frame-aligned pop freeze
// Optional build macro: SPRITE_MOTION_FRAME_DETECT_EN (derive frame tick from hcount/vcount).
// Ports: pixel_clk_in, rst_n_in (async active-low), hcount_in, vcount_in, new_frame_in,
//        run_in, pop_trigger_in; x_out, y_out, pop_out (registered), busy_out (POP state).
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int WIDTH      = 256,
    parameter int HEIGHT     = 256,
    parameter int SPEED_X    = 2,
    parameter int SPEED_Y    = 1,
    parameter int X_INIT     = 0,
    parameter int Y_INIT     = 0,
    parameter int POP_FRAMES = 30
) (
    input  logic           pixel_clk_in,
    input  logic           rst_n_in,
    input  logic [10:0]    hcount_in,
    input  logic [9:0]     vcount_in,
    input  logic           new_frame_in,
    input  logic           run_in,
    input  logic           pop_trigger_in,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           pop_out,
    output logic           busy_out
);

    localparam int CW = (POP_FRAMES > 1) ? $clog2(POP_FRAMES) : 1;

    logic          ft;
    motion_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          latch_q, latch_d;
    logic          pop_d;
    logic          trig_seen;
    logic          step;

`ifdef SPRITE_MOTION_FRAME_DETECT_EN
    // Rising edge of "first pixel of vertical blanking" so the tick fires once per frame.
    logic at_vblank, at_vblank_q;
    logic unused_new_frame;

    assign at_vblank        = (hcount_in == 11'd0) && (vcount_in == 10'(SCREEN_H));
    assign ft               = at_vblank & ~at_vblank_q;
    assign unused_new_frame = new_frame_in;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) at_vblank_q <= 1'b0;
        else           at_vblank_q <= at_vblank;
    end
`else
    logic unused_counts;

    assign ft            = new_frame_in;
    assign unused_counts = ^{hcount_in, vcount_in};
`endif

    // A trigger arriving on the tick cycle itself still counts for that tick.
    assign trig_seen = latch_q | (pop_trigger_in & (state_q == MOVE));

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= MOVE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MOVE: if (ft && trig_seen)        state_d = POP;
            POP:  if (ft && (cnt_q == '0))    state_d = MOVE;
            default:                          state_d = MOVE;
        endcase
    end

    always_comb begin
        latch_d = latch_q;
        cnt_d   = cnt_q;
        pop_d   = pop_out;
        step    = 1'b0;
        if (ft)
            latch_d = 1'b0;
        else if ((state_q == MOVE) && pop_trigger_in)
            latch_d = 1'b1;
        case (state_q)
            MOVE: begin
                if (ft) begin
                    if (trig_seen) begin
                        pop_d = 1'b1;
                        cnt_d = CW'(POP_FRAMES - 1);
                    end else begin
                        step = run_in;
                    end
                end
            end
            POP: begin
                if (ft) begin
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    else             pop_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            latch_q <= 1'b0;
            cnt_q   <= '0;
            pop_out <= 1'b0;
        end else begin
            latch_q <= latch_d;
            cnt_q   <= cnt_d;
            pop_out <= pop_d;
        end
    end

    assign busy_out = (state_q == POP);

    bounce_axis #(
        .LIMIT (SCREEN_W),
        .SIZE  (WIDTH),
        .SPEED (SPEED_X),
        .INIT  (X_INIT),
        .W     (X_W)
    ) u_axis_x (
        .clk   (pixel_clk_in),
        .rst_n (rst_n_in),
        .step  (step),
        .pos   (x_out)
    );

    bounce_axis #(
        .LIMIT (SCREEN_H),
        .SIZE  (HEIGHT),
        .SPEED (SPEED_Y),
        .INIT  (Y_INIT),
        .W     (Y_W)
    ) u_axis_y (
        .clk   (pixel_clk_in),
        .rst_n (rst_n_in),
        .step  (step),
        .pos   (y_out)
    );

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - directed self-checking bench for sprite_motion_ctrl
module tb_sprite_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = 11'd5;
    logic [9:0]  vcount = 10'd0;
    logic        new_frame = 1'b0;
    logic        run = 1'b0;
    logic        trig = 1'b0;

    logic [10:0] xa, xb, xc;
    logic [9:0]  ya, yb, yc;
    logic        pa, pb, pc, ba, bb, bc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl u_dut_a (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .new_frame_in(new_frame), .run_in(run), .pop_trigger_in(trig),
        .x_out(xa), .y_out(ya), .pop_out(pa), .busy_out(ba));

    sprite_motion_ctrl #(.X_INIT(1022), .Y_INIT(463)) u_dut_b (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .new_frame_in(new_frame), .run_in(run), .pop_trigger_in(trig),
        .x_out(xb), .y_out(yb), .pop_out(pb), .busy_out(bb));

    sprite_motion_ctrl #(.X_INIT(1100), .Y_INIT(500)) u_dut_c (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .new_frame_in(new_frame), .run_in(run), .pop_trigger_in(trig),
        .x_out(xc), .y_out(yc), .pop_out(pc), .busy_out(bc));

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame boundary; returns on the falling edge after the updating rising edge.
    task automatic frame_tick(input logic with_trig);
        @(negedge clk);
`ifdef SPRITE_MOTION_FRAME_DETECT_EN
        hcount = 11'd0;
        vcount = 10'd720;
`else
        new_frame = 1'b1;
`endif
        trig = with_trig;
        @(negedge clk);
        new_frame = 1'b0;
        hcount = 11'd5;
        vcount = 10'd0;
        trig = 1'b0;
    endtask

    task automatic pulse_trigger();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    initial begin
        int exp_x [3] = '{2, 4, 6};
        int exp_y [3] = '{1, 2, 3};
        int exp_xb[3] = '{1024, 1024, 1022};
        int exp_yb[3] = '{464, 464, 463};
        int exp_xc[3] = '{1024, 1022, 1020};
        int exp_yc[3] = '{464, 463, 462};

        repeat (3) @(negedge clk);
        check_eq("reset_x", xa, 0);
        check_eq("reset_y", ya, 0);
        check_eq("reset_pop", pa, 0);
        check_eq("reset_busy", ba, 0);
        check_eq("reset_xb", xb, 1022);
        rst_n = 1'b1;
        run = 1'b1;

        for (int i = 0; i < 3; i++) begin
            frame_tick(1'b0);
            check_eq($sformatf("move_x%0d", i), xa, exp_x[i]);
            check_eq($sformatf("move_y%0d", i), ya, exp_y[i]);
            check_eq($sformatf("rwall_x%0d", i), xb, exp_xb[i]);
            check_eq($sformatf("bwall_y%0d", i), yb, exp_yb[i]);
            check_eq($sformatf("oor_x%0d", i), xc, exp_xc[i]);
            check_eq($sformatf("oor_y%0d", i), yc, exp_yc[i]);
            repeat (4) @(negedge clk);
            check_eq($sformatf("hold_x%0d", i), xa, exp_x[i]);
            check_eq($sformatf("hold_y%0d", i), ya, exp_y[i]);
        end

        run = 1'b0;
        frame_tick(1'b0);
        check_eq("norun_x", xa, 6);
        run = 1'b1;
        frame_tick(1'b0);
        frame_tick(1'b0);
        check_eq("pre_pop_x", xa, 10);
        check_eq("pre_pop_y", ya, 5);

        // Latched trigger, then the tick enters POP without moving.
        pulse_trigger();
        check_eq("latched_nopop", pa, 0);
        frame_tick(1'b0);
        check_eq("pop_enter", pa, 1);
        check_eq("busy_enter", ba, 1);
        check_eq("pop_x_frozen", xa, 10);
        pulse_trigger();
        for (int i = 1; i < 30; i++) begin
            frame_tick(i == 5);
            check_eq($sformatf("pop_hold%0d", i), pa, 1);
            check_eq($sformatf("pop_x%0d", i), xa, 10);
        end
        frame_tick(1'b0);
        check_eq("pop_exit", pa, 0);
        check_eq("busy_exit", ba, 0);
        check_eq("pop_exit_x", xa, 10);
        frame_tick(1'b0);
        check_eq("resume_x", xa, 12);
        check_eq("resume_y", ya, 6);
        check_eq("no_retrigger", pa, 0);

        // Trigger coincident with the tick enters POP on that edge.
        frame_tick(1'b1);
        check_eq("simul_pop", pa, 1);
        check_eq("simul_x", xa, 12);
        repeat (17) frame_tick(1'b0);
        check_eq("midpop_busy", ba, 1);
        check_eq("midpop_x", xa, 12);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_x", xa, 0);
        check_eq("arst_y", ya, 0);
        check_eq("arst_pop", pa, 0);
        check_eq("arst_busy", ba, 0);
        check_eq("arst_xb", xb, 1022);
        @(negedge clk);
        rst_n = 1'b1;
        frame_tick(1'b0);
        check_eq("post_rst_x", xa, 2);
        check_eq("post_rst_pop", pa, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Upstream driver for the image sprite stage. Produces the sprite's top-left position (x_out, y_out) and the pop frame-select (pop_out), all in the pixel clock domain.
- Position bounces inside the 1280x720 active area.
- A pop trigger freezes motion and asserts pop_out for a fixed number of frames.
- All updates occur only at frame boundaries, so the sprite never tears mid-frame.

Parameters:
WIDTH, 256, sprite width in pixels; must match the sprite stage.
HEIGHT, 256, sprite height in pixels.
SPEED_X, 2, horizontal step per frame in pixels, 1..WIDTH.
SPEED_Y, 1, vertical step per frame in pixels, 1..HEIGHT.
X_INIT, 0, reset x position.
Y_INIT, 0, reset y position.
POP_FRAMES, 30, number of frames pop_out stays high per trigger, >=1.

Ports:
pixel_clk_in  input  1  pixel clock; all logic in this domain
rst_n_in  input  1  asynchronous active-low reset
hcount_in  input  11  current pixel column
vcount_in  input  10  current pixel row
new_frame_in  input  1  single-cycle frame-boundary pulse
run_in  input  1  motion enable, level-sensitive
pop_trigger_in  input  1  single-cycle pop request
x_out  output  11  sprite left edge, registered
y_out  output  10  sprite top edge, registered
pop_out  output  1  high = pop frame selected, registered
busy_out  output  1  high while in POP state

Behaviour:
- Reset (async assert, sync release): x_out=X_INIT, y_out=Y_INIT, x and y directions = positive (right/down), pop_out=0, busy_out=0, trigger latch=0, frame counter=0, state=MOVE.
- Frame tick (ft): new_frame_in sampled high. Every state and output change happens on the clock edge that samples ft, so outputs are valid the next cycle (latency 1). Between ticks, outputs are held constant.
- Trigger latch: set when pop_trigger_in=1 in MOVE; cleared on ft.
  - A trigger in the same cycle as ft counts for that ft.
  - Triggers in POP are ignored and never latched.
- State MOVE:
  - On ft with latch=1: go to POP, pop_out<=1, busy_out<=1, counter<=POP_FRAMES-1. Position is not updated on this tick.
  - On ft with latch=0 and run_in=1: update each axis per the axis rule below.
  - On ft with latch=0 and run_in=0: hold position.
- State POP:
  - On ft with counter!=0: counter decrements; position stays frozen.
  - On ft with counter==0: go to MOVE, pop_out<=0, busy_out<=0. Motion resumes from the next ft.
- Axis rule, x (y identical with SPEED_Y, HEIGHT, 720):
  - Moving right: if x+SPEED_X+WIDTH > 1280, then x<=1280-WIDTH and direction flips to left; else x<=x+SPEED_X.
  - Moving left: if x < SPEED_X, then x<=0 and direction flips to right; else x<=x-SPEED_X.
  - Compute the comparisons 1 bit wider than the position; no wrap-around is permitted.
- Out-of-range start: if X_INIT > 1280-WIDTH, the first moving tick clamps to 1280-WIDTH and flips direction. Same for y.
- Reset during POP aborts immediately to the reset values.

Optional Feature:
SPRITE_MOTION_FRAME_DETECT_EN
- Defined: new_frame_in is ignored. ft is generated internally as a one-cycle pulse on the first cycle with hcount_in==0 && vcount_in==720 (start of vertical blanking), edge-detected so it fires once per frame.
- Undefined: ft = new_frame_in; hcount_in and vcount_in are unused.

Decomposition:
- Package sprite_pkg holds:
  - SCREEN_W=1280, SCREEN_H=720
  - typedef enum {MOVE, POP} motion_state_t
  - position widths X_W=11, Y_W=10
- Sub-module bounce_axis (parameters LIMIT, SIZE, SPEED, INIT, W):
  - holds one axis position and direction; advances on a step strobe.
  - Instantiated twice, with step = ft & MOVE & !latch & run_in.

Test Plan:
- Reset then run_in=1, 3 ticks -> x_out 0,2,4,6 and y_out 0,1,2,3; outputs constant between ticks.
- Right wall: X_INIT=1022, dir right -> tick1 x=1024; tick2 x=1024 with dir flipped left; tick3 x=1022.
- Bottom wall: Y_INIT=463 -> tick1 y=464; tick2 y=464 with dir up; tick3 y=463.
- Pop: trigger at x=10, then ft -> pop_out=1 and busy_out=1 one cycle later, x frozen at 10 for 30 ticks. On the 30th ft pop_out=0. The next ft gives x=12. A retrigger during POP has no effect.
- Simultaneous pop_trigger_in and new_frame_in in MOVE -> POP entered on that edge; x not advanced.
- Assert rst_n_in mid-POP (counter=12) -> immediately x=X_INIT, y=Y_INIT, pop_out=0, busy_out=0. With SPRITE_MOTION_FRAME_DETECT_EN defined, sweep hcount/vcount -> exactly one update per frame at (0,720).
